// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment scan driver: shadowed digit register, refresh divider, registered active-low outputs.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_LZB_EN.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk_in,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic                    load,
    input  logic                    hex_mode,
    input  logic                    blank,
    output logic [6:0]              seven_seg,
    output logic [NUM_DIGITS-1:0]   anode
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic                    scanTick;
    logic [3:0]              curNibble;
    logic                    lzbBlank;

    function automatic logic [6:0] decodeNibble(input logic [3:0] code, input logic hexEn);
        logic [6:0] pattern;
        case (code)
            4'h0:    pattern = 7'b1000000;
            4'h1:    pattern = 7'b1111001;
            4'h2:    pattern = 7'b0100100;
            4'h3:    pattern = 7'b0110000;
            4'h4:    pattern = 7'b0011001;
            4'h5:    pattern = 7'b0010010;
            4'h6:    pattern = 7'b0000010;
            4'h7:    pattern = 7'b1111000;
            4'h8:    pattern = 7'b0000000;
            4'h9:    pattern = 7'b0010000;
            4'hA:    pattern = hexEn ? 7'b0001000 : 7'b1111111;
            4'hB:    pattern = hexEn ? 7'b0000011 : 7'b1111111;
            4'hC:    pattern = hexEn ? 7'b1000110 : 7'b1111111;
            4'hD:    pattern = hexEn ? 7'b0100001 : 7'b1111111;
            4'hE:    pattern = hexEn ? 7'b0000110 : 7'b1111111;
            default: pattern = hexEn ? 7'b0001110 : 7'b1111111;
        endcase
        return pattern;
    endfunction

    // Counter, index and shadow advance together; a load on a tick edge is seen by the new index.
    always_comb begin
        scanTick = (cnt_q == CNT_LAST);
        cnt_d    = scanTick ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        if (scanTick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        shadow_d = load ? digits : shadow_q;
    end

    always_comb begin
        curNibble = shadow_q[{idx_q, 2'b00} +: 4];
`ifdef SEVEN_SEG_LZB_EN
        lzbBlank = (idx_q != '0) && ((shadow_q >> {idx_q, 2'b00}) == '0);
`else
        lzbBlank = 1'b0;
`endif
        if (blank) begin
            anode_d = '1;
            seg_d   = 7'b1111111;
        end else begin
            anode_d = ~(NUM_DIGITS'(1) << idx_q);
            seg_d   = lzbBlank ? 7'b1111111 : decodeNibble(curNibble, hex_mode);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            seg_q    <= 7'b1111111;
            anode_q  <= '1;
        end else begin
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            anode_q  <= anode_d;
        end
    end

    assign seven_seg = seg_q;
    assign anode     = anode_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver (4 digits, 4-cycle refresh) against a cycle-count based display model.
module tb_seven_seg_scan_driver;

    localparam int ND = 4;
    localparam int RD = 4;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b0;
    logic [15:0] digits = '0;
    logic        load = 1'b0;
    logic        hex_mode = 1'b0;
    logic        blank = 1'b0;
    logic [6:0]  seven_seg;
    logic [3:0]  anode;

    int          checks = 0;
    int          failures = 0;
    int          edgeCount = 0;
    logic [15:0] modelShadow = '0;
    logic        curHex = 1'b0;
    logic        curBlank = 1'b0;

    logic [6:0] decTable [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    logic [6:0] hexTable [6]  = '{7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    seven_seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .digits(digits), .load(load),
        .hex_mode(hex_mode), .blank(blank), .seven_seg(seven_seg), .anode(anode)
    );

    always #5 clk_in = ~clk_in;

    // What the display should show for a given shadow value, position and mode inputs.
    function automatic logic [6:0] expectedSeg(input logic [15:0] sh, input int pos, input logic hx, input logic bl);
        logic [3:0] nib;
        if (bl) return 7'b1111111;
        nib = sh[4*pos +: 4];
`ifdef SEVEN_SEG_LZB_EN
        if (pos > 0 && (sh >> (4*pos)) == 16'h0) return 7'b1111111;
`endif
        if (nib < 10) return decTable[nib];
        if (hx) return hexTable[nib - 10];
        return 7'b1111111;
    endfunction

    task automatic checkOutput(input string tag, input logic [3:0] expAnode, input logic [6:0] expSeg);
        checks++;
        assert (anode === expAnode) else begin
            failures++;
            $error("FAIL %s anode observed=%b expected=%b", tag, anode, expAnode);
        end
        checks++;
        assert (seven_seg === expSeg) else begin
            failures++;
            $error("FAIL %s seven_seg observed=%b expected=%b", tag, seven_seg, expSeg);
        end
    endtask

    // Called at a falling edge: drive inputs, run one rising edge, compare against the model.
    task automatic applyStimulus(input logic ld, input logic [15:0] dg, input logic hx, input logic bl, input string tag);
        int         pos;
        logic [3:0] expAnode;
        logic [6:0] expSeg;
        load = ld; digits = dg; hex_mode = hx; blank = bl;
        curHex = hx; curBlank = bl;
        pos = (edgeCount / RD) % ND;
        expAnode = bl ? 4'b1111 : (4'b1111 & ~(4'b0001 << pos));
        expSeg = expectedSeg(modelShadow, pos, hx, bl);
        @(posedge clk_in);
        if (ld) modelShadow = dg;
        edgeCount++;
        #1;
        checkOutput(tag, expAnode, expSeg);
        @(negedge clk_in);
        load = 1'b0;
    endtask

    task automatic runCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0, curHex, curBlank, tag);
    endtask

    // Hold inputs until the given position is lit, then compare its pattern to a fixed value.
    task automatic waitForPos(input int pos, input logic [6:0] wantSeg, input string tag);
        logic [3:0] wantAnode;
        bit found;
        wantAnode = 4'b1111 & ~(4'b0001 << pos);
        found = 0;
        for (int i = 0; i < 24 && !found; i++) begin
            applyStimulus(1'b0, 16'h0, curHex, curBlank, tag);
            if (anode === wantAnode) found = 1;
        end
        checks++;
        assert (found && seven_seg === wantSeg) else begin
            failures++;
            $error("FAIL %s pos%0d seven_seg observed=%b expected=%b found=%0d", tag, pos, seven_seg, wantSeg, found);
        end
    endtask

    initial begin
        logic [15:0] rd;
        repeat (2) @(posedge clk_in);
        #1;
        checkOutput("resetState", 4'b1111, 7'b1111111);

        @(negedge clk_in);
        rst_n = 1'b1;
        edgeCount = 0;
        modelShadow = '0;
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, "firstEdge");
        checkOutput("firstEdgeConst", 4'b1110, 7'b1000000);
        runCycles(3, "noLoad");
        checkOutput("noLoadPos0", 4'b1110, 7'b1000000);
        runCycles(1, "step1");
        checkOutput("step1101", 4'b1101, 7'b1000000);
        runCycles(4, "step2");
        checkOutput("step1011", 4'b1011, 7'b1000000);
        runCycles(4, "step3");
        checkOutput("step0111", 4'b0111, 7'b1000000);
        runCycles(4, "step4");
        checkOutput("step1110", 4'b1110, 7'b1000000);

        applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0, "load1234");
        waitForPos(0, 7'b0011001, "dec1234");
        waitForPos(3, 7'b1111001, "dec1234");

        applyStimulus(1'b1, 16'hABCF, 1'b0, 1'b0, "loadABCF");
        for (int p = 0; p < ND; p++) waitForPos(p, 7'b1111111, "abcfDec");
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, "hexOn");
        waitForPos(0, 7'b0001110, "abcfHex");
        waitForPos(3, 7'b0001000, "abcfHex");

        runCycles(2, "preBlank");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, "blank");
            checkOutput("blankConst", 4'b1111, 7'b1111111);
        end
        runCycles(1, "unblank");
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, "resume");
        runCycles(12, "resume");

        applyStimulus(1'b1, 16'h0050, 1'b0, 1'b0, "load0050");
`ifdef SEVEN_SEG_LZB_EN
        waitForPos(3, 7'b1111111, "lzb0050");
        waitForPos(2, 7'b1111111, "lzb0050");
`else
        waitForPos(3, 7'b1000000, "lz0050");
        waitForPos(2, 7'b1000000, "lz0050");
`endif
        waitForPos(1, 7'b0010010, "pos1_0050");
        waitForPos(0, 7'b1000000, "pos0_0050");

        for (int i = 0; i < 200; i++) begin
            rd = 16'($urandom);
            if ($urandom_range(0, 1) == 0) rd = rd >> (4 * $urandom_range(1, 3));
            applyStimulus($urandom_range(0, 3) == 0, rd, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 7) == 0, "random");
        end

        applyStimulus(1'b1, 16'h9876, 1'b0, 1'b0, "load9876");
        runCycles(5, "pre9876");
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncReset", 4'b1111, 7'b1111111);
        load = 1'b1;
        digits = 16'hFFFF;
        repeat (2) @(posedge clk_in);
        #1;
        checkOutput("holdReset", 4'b1111, 7'b1111111);
        @(negedge clk_in);
        load = 1'b0;
        rst_n = 1'b1;
        edgeCount = 0;
        modelShadow = '0;
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, "postReset");
        checkOutput("postResetConst", 4'b1110, 7'b1000000);
        runCycles(16, "postReset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_driver.md
SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digit positions (legal 1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, clk_in cycles each digit is held active (legal >= 2).
REQ-003 SHALL have port clk_in  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port digits  input  4*NUM_DIGITS  nibble per position, bits [3:0] = position 0 (rightmost).
REQ-006 SHALL have port load  input  1  capture digits into shadow register when high at a clock edge.
REQ-007 SHALL have port hex_mode  input  1  1 = decode 0-F; 0 = decode 0-9, codes 10-15 blank.
REQ-008 SHALL have port blank  input  1  force display dark while high.
REQ-009 SHALL have port seven_seg  output  7  registered segment pattern, active-low, bit order gfedcba.
REQ-010 SHALL have port anode  output  NUM_DIGITS  registered digit enable, active-low, one-hot-cold.

Function
REQ-011 SHALL hold a shadow register of 4*NUM_DIGITS bits; load=1 at an edge writes digits into it; load=0 holds it.
REQ-012 SHALL run a refresh counter 0..REFRESH_DIV-1, wrapping to 0; the cycle at REFRESH_DIV-1 is the scan tick.
REQ-013 SHALL advance scan index on each scan tick, NUM_DIGITS-1 wrapping to 0; with NUM_DIGITS=1 index stays 0.
REQ-014 SHALL register outputs with one-cycle latency: anode/seven_seg at edge N+1 reflect index, shadow, hex_mode, blank as of edge N.
REQ-015 SHALL drive anode with only bit [index] low when blank=0.
REQ-016 SHALL decode decimal 0-9 as 1000000,1111001,0100100,0110000,0011001,0010010,0000010,1111000,0000000,0010000.
REQ-017 SHALL decode, when hex_mode=1, A-F as 0001000,0000011,1000110,0100001,0000110,0001110.
REQ-018 SHALL output 1111111 for codes 10-15 when hex_mode=0.
REQ-019 SHALL drive anode all-ones and seven_seg 1111111 while blank=1; counter and index keep running.
REQ-020 SHALL, when load coincides with a scan tick, use the newly loaded shadow data for the new index.
REQ-021 SHALL treat hex_mode changes as taking effect on the next output update with no other side effect.

Reset
REQ-022 SHALL, while rst_n=0, immediately force shadow=0, refresh counter=0, index=0, anode all-ones, seven_seg=1111111.
REQ-023 SHALL ignore load while rst_n=0; a reset mid-scan restarts scanning at position 0 with a full REFRESH_DIV period.
REQ-024 SHALL, after rst_n rises, show position 0 with digit 0 (1000000) from the first clock edge.

Configuration
REQ-025 SHALL support macro SEVEN_SEG_LZB_EN (leading-zero blanking).
REQ-026 SHALL, with SEVEN_SEG_LZB_EN defined, output 1111111 for any position above position 0 whose nibble and all higher nibbles are zero; anode still scans normally.
REQ-027 SHALL, without SEVEN_SEG_LZB_EN, display every position's decoded value including leading zeros.

Verification (bench: NUM_DIGITS=4, REFRESH_DIV=4)
REQ-028 SHALL cover: reset release, no load -> anode 1110, seven_seg 1000000; anode steps 1101,1011,0111,1110 every 4 cycles.
REQ-029 SHALL cover: load digits=16'h1234, hex_mode=0 -> position 0 shows 0011001, position 3 shows 1111001.
REQ-030 SHALL cover: load 16'hABCF; hex_mode=0 -> all positions 1111111; hex_mode=1 -> position 0 shows 0001110, position 3 shows 0001000.
REQ-031 SHALL cover: blank=1 for 10 cycles mid-scan -> anode 1111, seven_seg 1111111; on release scan resumes at the index the counters reached.
REQ-032 SHALL cover: SEVEN_SEG_LZB_EN defined, load 16'h0050 -> positions 3,2 show 1111111, position 1 shows 0010010, position 0 shows 1000000; macro undefined -> positions 3,2 show 1000000.
REQ-033 SHALL cover: rst_n low asynchronously mid-period with shadow 16'h9876 -> outputs dark within same cycle; after release position 0 shows 1000000.
